fc_layer_par: RTL and testbench

FC_LAYER_PAR -- requirements
Module: fc_layer_par

---
 rtl/fc_layer_par_pkg.sv | 44 ++++
 rtl/fc_layer_par_if.sv | 29 ++
 rtl/fc_mac_lane.sv | 52 +++++
 rtl/fc_layer_par.sv | 206 ++++++++++++++++++++
 tb/tb_fc_layer_par.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_par_pkg.sv
// Shared definitions for the parallel fully-connected layer: FSM state
// encoding, pipeline constants and saturating arithmetic helpers.
package fc_layer_par_pkg;

  typedef enum logic [2:0] {
    LOAD_W,
    LOAD_X,
    COMPUTE,
    DRAIN,
    OUTPUT
  } fc_state_t;

  // Cycles needed after the last address to flush the read and multiply registers
  localparam int DRAIN_CYCLES = 2;

  // Largest value representable in t-bit two's complement
  function automatic longint sat_max(input int t);
    return (longint'(1) <<< (t - 1)) - longint'(1);
  endfunction

  // Smallest value representable in t-bit two's complement
  function automatic longint sat_min(input int t);
    return -(longint'(1) <<< (t - 1));
  endfunction

  // Clamp a wide value into the t-bit signed range
  function automatic longint sat_clamp(input longint v, input int t);
    if (v > sat_max(t)) return sat_max(t);
    if (v < sat_min(t)) return sat_min(t);
    return v;
  endfunction

  // Full-precision product (2t bits fits in 64 for t <= 32), then clamp to t bits
  function automatic longint sat_mul(input longint a, input longint b, input int t);
    return sat_clamp(a * b, t);
  endfunction

  // Both operands are already t-bit values, so the wide sum only leaves the
  // t-bit range exactly when the t-bit add would overflow; clamp it there
  function automatic longint sat_add(input longint a, input longint b, input int t);
    return sat_clamp(a + b, t);
  endfunction

endpackage

// File: rtl/fc_layer_par_if.sv
// Stream bus of the fully-connected layer: weight, input and output
// valid/ready channels plus the busy status flag.
interface fc_layer_par_if #(parameter int T = 16);

  logic                w_valid;
  logic                w_ready;
  logic signed [T-1:0] w_data;

  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;

  logic                output_valid;
  logic                output_ready;
  logic signed [T-1:0] output_data;

  logic                busy;

  modport master (
    output w_valid, w_data, input_valid, input_data, output_ready,
    input  w_ready, input_ready, output_valid, output_data, busy
  );

  modport slave (
    input  w_valid, w_data, input_valid, input_data, output_ready,
    output w_ready, input_ready, output_valid, output_data, busy
  );

endinterface

// File: rtl/fc_mac_lane.sv
// One MAC lane: saturating multiply into a delay register, saturating
// accumulate, and optional ReLU on the look-ahead result.
module fc_mac_lane
  import fc_layer_par_pkg::*;
#(
  parameter int T    = 16,
  parameter int RELU = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [T-1:0] x,
  input  logic signed [T-1:0] w,
  output logic signed [T-1:0] y_next
);

  logic signed [T-1:0] prod_q;
  logic signed [T-1:0] acc;
  logic signed [T-1:0] acc_next;
  logic                prod_valid;

  // Register the saturated product so the multiplier stays out of the accumulate path
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_valid <= 1'b0;
      prod_q     <= '0;
    end else begin
      prod_valid <= in_valid;
      prod_q     <= T'(sat_mul(longint'(x), longint'(w), T));
    end
  end

  // Next accumulator value; also lets the top capture the final sum on the last add
  always_comb begin
    acc_next = acc;
    if (prod_valid) acc_next = T'(sat_add(longint'(acc), longint'(prod_q), T));
  end

  // Accumulator, cleared at the start of every row group
  always_ff @(posedge clk) begin
    if (reset || clear) acc <= '0;
    else                acc <= acc_next;
  end

  // Activation applied to the look-ahead sum
  always_comb begin
    y_next = acc_next;
    if (RELU != 0 && acc_next < 0) y_next = '0;
  end

endmodule

// File: rtl/fc_layer_par.sv
// Fully-connected layer y = act(W*x) with P parallel MAC lanes. Weights are
// streamed once after reset into per-lane banks; each input vector is then
// processed in M/P row groups of P rows.
module fc_layer_par
  import fc_layer_par_pkg::*;
#(
  parameter int T    = 16,
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int P    = 2,
  parameter int RELU = 1
) (
  input logic           clk,
  input logic           reset,
  fc_layer_par_if.slave bus
);

  localparam int G   = M / P;
  localparam int WD  = G * N;
  localparam int XAW = (N  > 1) ? $clog2(N)  : 1;
  localparam int WAW = (WD > 1) ? $clog2(WD) : 1;
  localparam int LW  = (P  > 1) ? $clog2(P)  : 1;
  localparam int GW  = (G  > 1) ? $clog2(G)  : 1;

  if (M % P != 0) begin : g_bad_lane_count
    $error("fc_layer_par: M must be a multiple of P");
  end

  fc_state_t           state;
  logic [XAW-1:0]      col_cnt;
  logic [LW-1:0]       lane_cnt;
  logic [GW-1:0]       grp_cnt;
  logic [WAW-1:0]      w_base;
  logic [WAW-1:0]      rd_addr;
  logic [1:0]          drain_cnt;
  logic                rd_valid;
  logic                acc_clear;
  logic                w_fire;
  logic                x_fire;
  logic                y_fire;
  logic                col_last;
  logic                lane_last;
  logic                grp_last;
  logic [WAW-1:0]      wr_addr;
  logic [LW-1:0]       pick_lane;
  logic signed [T-1:0] out_pick;
  logic signed [T-1:0] x_mem [N];
  logic signed [T-1:0] x_rd;
  logic signed [T-1:0] y_next [P];

  // Handshake and counter-terminal decodes shared by the datapath and FSM
  always_comb begin
    w_fire    = bus.w_valid && bus.w_ready;
    x_fire    = bus.input_valid && bus.input_ready;
    y_fire    = bus.output_valid && bus.output_ready;
    col_last  = (col_cnt == XAW'(N - 1));
    lane_last = (lane_cnt == LW'(P - 1));
    grp_last  = (grp_cnt == GW'(G - 1));
    wr_addr   = w_base + WAW'(col_cnt);
    acc_clear = (state == COMPUTE) && (col_cnt == '0);
  end

  // Choose which lane result feeds the output register next
  always_comb begin
    pick_lane = '0;
    if (state == OUTPUT && !lane_last) pick_lane = lane_cnt + LW'(1);
    out_pick = y_next[pick_lane];
  end

  // Shared x buffer: written while loading, read one element per COMPUTE cycle
  always_ff @(posedge clk) begin
    if (x_fire) x_mem[col_cnt] <= bus.input_data;
    if (state == COMPUTE) x_rd <= x_mem[col_cnt];
  end

  // Marks read registers holding data issued during COMPUTE
  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= (state == COMPUTE);
  end

  for (genvar b = 0; b < P; b++) begin : g_lane
    logic signed [T-1:0] bank [WD];
    logic signed [T-1:0] w_rd;

    // Bank b holds rows b, b+P, b+2P, ... at address group*N + column
    always_ff @(posedge clk) begin
      if (w_fire && lane_cnt == LW'(b)) bank[wr_addr] <= bus.w_data;
      if (state == COMPUTE) w_rd <= bank[rd_addr];
    end

    fc_mac_lane #(
      .T    (T),
      .RELU (RELU)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear    (acc_clear),
      .in_valid (rd_valid),
      .x        (x_rd),
      .w        (w_rd),
      .y_next   (y_next[b])
    );
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= LOAD_W;
      col_cnt          <= '0;
      lane_cnt         <= '0;
      grp_cnt          <= '0;
      w_base           <= '0;
      rd_addr          <= '0;
      drain_cnt        <= '0;
      bus.w_ready      <= 1'b1;
      bus.input_ready  <= 1'b0;
      bus.output_valid <= 1'b0;
      bus.output_data  <= '0;
      bus.busy         <= 1'b1;
    end else begin
      unique case (state)
        LOAD_W: begin
          if (w_fire) begin
            if (!col_last) begin
              col_cnt <= col_cnt + XAW'(1);
            end else begin
              col_cnt <= '0;
              if (!lane_last) begin
                lane_cnt <= lane_cnt + LW'(1);
              end else begin
                lane_cnt <= '0;
                w_base   <= w_base + WAW'(N);
                if (!grp_last) begin
                  grp_cnt <= grp_cnt + GW'(1);
                end else begin
                  grp_cnt         <= '0;
                  state           <= LOAD_X;
                  bus.w_ready     <= 1'b0;
                  bus.input_ready <= 1'b1;
                  bus.busy        <= 1'b0;
                end
              end
            end
          end
        end
        LOAD_X: begin
          if (x_fire) begin
            if (!col_last) begin
              col_cnt <= col_cnt + XAW'(1);
            end else begin
              col_cnt         <= '0;
              grp_cnt         <= '0;
              rd_addr         <= '0;
              state           <= COMPUTE;
              bus.input_ready <= 1'b0;
              bus.busy        <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          rd_addr <= rd_addr + WAW'(1);
          if (col_last) begin
            col_cnt   <= '0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            col_cnt <= col_cnt + XAW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
            state            <= OUTPUT;
            lane_cnt         <= '0;
            bus.output_valid <= 1'b1;
            bus.output_data  <= out_pick;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        OUTPUT: begin
          if (y_fire) begin
            if (!lane_last) begin
              lane_cnt        <= lane_cnt + LW'(1);
              bus.output_data <= out_pick;
            end else begin
              lane_cnt         <= '0;
              bus.output_valid <= 1'b0;
              if (grp_last) begin
                grp_cnt         <= '0;
                state           <= LOAD_X;
                bus.input_ready <= 1'b1;
                bus.busy        <= 1'b0;
              end else begin
                grp_cnt <= grp_cnt + GW'(1);
                state   <= COMPUTE;
              end
            end
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_par.sv
// Bench for fc_layer_par: two instances (ReLU on / bypass) share one
// stimulus stream; results are compared with an arithmetic reference model.
module tb_fc_layer_par;

  localparam int T = 16;
  localparam int M = 4;
  localparam int N = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  int w_m [M][N];
  int x_v [N];
  int exp_r [M];
  int exp_b [M];
  int lat;
  int seen;

  always #5 clk = ~clk;

  fc_layer_par_if #(.T(T)) bus_r ();
  fc_layer_par_if #(.T(T)) bus_b ();

  assign bus_b.w_valid      = bus_r.w_valid;
  assign bus_b.w_data       = bus_r.w_data;
  assign bus_b.input_valid  = bus_r.input_valid;
  assign bus_b.input_data   = bus_r.input_data;
  assign bus_b.output_ready = bus_r.output_ready;

  fc_layer_par #(.T(T), .M(M), .N(N), .P(P), .RELU(1)) dut_r (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r)
  );

  fc_layer_par #(.T(T), .M(M), .N(N), .P(P), .RELU(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rand_full();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int rand_small();
    return int'($urandom_range(200)) - 100;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic compute_model();
    longint acc;
    for (int r = 0; r < M; r++) begin
      acc = 0;
      for (int c = 0; c < N; c++)
        acc = clamp16(acc + clamp16(longint'(w_m[r][c]) * longint'(x_v[c])));
      exp_b[r] = int'(acc);
      exp_r[r] = (acc < 0) ? 0 : int'(acc);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus_r.w_valid = 1'b0;
    bus_r.input_valid = 1'b0;
    bus_r.output_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_weights();
    int n;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        bus_r.w_valid = 1'b1;
        bus_r.w_data  = T'(w_m[r][c]);
        n = 0;
        while (bus_r.w_ready !== 1'b1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (n >= 50) check("w_ready_timeout", bus_r.w_ready, 1);
        @(negedge clk);
      end
    end
    bus_r.w_valid = 1'b0;
  endtask

  task automatic send_x();
    int n;
    for (int c = 0; c < N; c++) begin
      bus_r.input_valid = 1'b1;
      bus_r.input_data  = T'(x_v[c]);
      n = 0;
      while (bus_r.input_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("input_ready_timeout", bus_r.input_ready, 1);
      @(negedge clk);
    end
    bus_r.input_valid = 1'b0;
  endtask

  task automatic wait_first_y(output int l);
    l = 1;
    while (bus_r.output_valid !== 1'b1 && l < 60) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic check_output(input int hold_cycles, input string tag);
    int got, n, held;
    bit rdy, pend;
    logic signed [T-1:0] held_r, held_b;
    got = 0; n = 0; held = 0; pend = 1'b0;
    held_r = '0; held_b = '0;
    while (got < M && n < 500) begin
      if (pend) begin
        check({tag, "_hold_valid"}, bus_r.output_valid, 1);
        check({tag, "_hold_data_r"}, bus_r.output_data, held_r);
        check({tag, "_hold_data_b"}, bus_b.output_data, held_b);
      end
      if (hold_cycles > 0)      rdy = (held >= hold_cycles);
      else if (hold_cycles < 0) rdy = ($urandom_range(3) != 0);
      else                      rdy = 1'b1;
      bus_r.output_ready = rdy;
      pend = 1'b0;
      if (bus_r.output_valid === 1'b1) begin
        if (rdy) begin
          check({tag, "_y_relu"}, bus_r.output_data, exp_r[got]);
          check({tag, "_y_bypass"}, bus_b.output_data, exp_b[got]);
          got++;
        end else begin
          pend = 1'b1;
          held_r = bus_r.output_data;
          held_b = bus_b.output_data;
          held++;
        end
      end
      @(negedge clk);
      n++;
    end
    bus_r.output_ready = 1'b0;
    if (got != M) check({tag, "_count"}, got, M);
    check({tag, "_valid_after"}, bus_r.output_valid, 0);
    check({tag, "_input_ready_after"}, bus_r.input_ready, 1);
    check({tag, "_busy_after"}, bus_r.busy, 0);
  endtask

  task automatic run_vector(input int hold_cycles, input string tag);
    compute_model();
    send_x();
    wait_first_y(lat);
    check({tag, "_latency"}, lat, N + 3);
    check_output(hold_cycles, tag);
  endtask

  initial begin
    bus_r.w_valid = 1'b0;
    bus_r.w_data = '0;
    bus_r.input_valid = 1'b0;
    bus_r.input_data = '0;
    bus_r.output_ready = 1'b0;
    reset = 1'b1;

    $display("[TB] reset values");
    apply_reset();
    check("rst_output_valid", bus_r.output_valid, 0);
    check("rst_output_data", bus_r.output_data, 0);
    check("rst_input_ready", bus_r.input_ready, 0);
    check("rst_w_ready", bus_r.w_ready, 1);
    check("rst_busy", bus_r.busy, 1);

    $display("[TB] identity weights, output stall, back-to-back vectors");
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = (r == c) ? 1 : 0;
    apply_weights();
    check("loaded_w_ready", bus_r.w_ready, 0);
    check("loaded_input_ready", bus_r.input_ready, 1);
    check("loaded_busy", bus_r.busy, 0);
    x_v = '{1, 2, 3, 4};
    run_vector(10, "ident");
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < N; c++) x_v[c] = rand_full();
      run_vector(-1, "ident_b2b");
    end

    $display("[TB] negative row and ReLU");
    apply_reset();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = (r == 0) ? -1 : rand_small();
    apply_weights();
    x_v = '{5, 5, 5, 5};
    run_vector(0, "neg_row");

    $display("[TB] product saturation");
    apply_reset();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = 300;
    apply_weights();
    x_v = '{300, 300, 300, 300};
    run_vector(0, "sat_mul");

    $display("[TB] accumulator saturation, positive then negative");
    apply_reset();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = 200;
    apply_weights();
    x_v = '{100, 100, 100, 100};
    run_vector(0, "sat_add_pos");
    apply_reset();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = -200;
    apply_weights();
    run_vector(-1, "sat_add_neg");

    $display("[TB] random weights and vectors");
    apply_reset();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = ($urandom_range(1) != 0) ? rand_full() : rand_small();
    apply_weights();
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < N; c++) x_v[c] = ($urandom_range(1) != 0) ? rand_full() : rand_small();
      run_vector(-1, "random");
    end

    $display("[TB] reset during compute");
    for (int c = 0; c < N; c++) x_v[c] = rand_small();
    send_x();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_output_valid", bus_r.output_valid, 0);
    check("midrst_w_ready", bus_r.w_ready, 1);
    check("midrst_input_ready", bus_r.input_ready, 0);
    seen = 0;
    bus_r.input_valid = 1'b1;
    bus_r.input_data = 16'sd7;
    bus_r.output_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_r.output_valid !== 1'b0 || bus_b.output_valid !== 1'b0) seen++;
      if (bus_r.input_ready !== 1'b0) seen++;
    end
    check("midrst_quiet", seen, 0);
    bus_r.input_valid = 1'b0;
    bus_r.output_ready = 1'b0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = rand_small();
    apply_weights();
    for (int c = 0; c < N; c++) x_v[c] = rand_small();
    run_vector(-1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
